// File: rtl/kmer_minhash.sv
// MinHash signature builder: drains 32-bit k-mers, keeps per-hash running minima, streams the signature on seq_end.
// Optional KMER_MINHASH_COUNT_EN adds a saturating per-sequence k-mer counter output.
module kmer_minhash #(
    parameter int unsigned NUM_HASHES = 4,
    parameter logic [31:0] HASH_A     = 32'h9E3779B1,
    parameter logic [31:0] HASH_B     = 32'h0,
    localparam int unsigned IDX_W     = (NUM_HASHES > 1) ? $clog2(NUM_HASHES) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      kmer_data,
    input  logic             kmer_full,
    output logic             kmer_read,
    input  logic             seq_end,
    output logic             sig_valid,
    input  logic             sig_ready,
    output logic [IDX_W-1:0] sig_index,
    output logic [31:0]      sig_value,
    output logic             busy
`ifdef KMER_MINHASH_COUNT_EN
    ,
    output logic [15:0]      kmer_count
`endif
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_HASHES - 1);

    typedef enum logic [1:0] {IDLE, HASH, EMIT} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      kmer_q, kmer_d;
    logic             end_pend_q, end_pend_d;
    logic [31:0]      min_q [NUM_HASHES];
    logic [31:0]      min_d [NUM_HASHES];
    logic             clear_c;
    logic [31:0]      a_c, b_c, h_c;

    // Per-index universal hash coefficients: a_i = A + 2i (stays odd), b_i = B + i.
    always_comb begin
        a_c = HASH_A + (32'(idx_q) << 1);
        b_c = HASH_B + 32'(idx_q);
        h_c = a_c * kmer_q + b_c;
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        kmer_d    = kmer_q;
        min_d     = min_q;
        kmer_read = 1'b0;
        sig_valid = 1'b0;
        clear_c   = 1'b0;
        case (state_q)
            IDLE: begin
                // Buffered k-mers are drained before a pending signature is emitted.
                if (kmer_full) begin
                    kmer_read = 1'b1;
                    kmer_d    = kmer_data;
                    idx_d     = '0;
                    state_d   = HASH;
                end else if (end_pend_q) begin
                    idx_d   = '0;
                    state_d = EMIT;
                end
            end
            HASH: begin
                if (h_c < min_q[idx_q]) begin
                    min_d[idx_q] = h_c;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            EMIT: begin
                sig_valid = 1'b1;
                if (sig_ready) begin
                    if (idx_q == LAST_IDX) begin
                        clear_c = 1'b1;
                        idx_d   = '0;
                        state_d = IDLE;
                        for (int i = 0; i < int'(NUM_HASHES); i++) begin
                            min_d[i] = 32'hFFFF_FFFF;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A seq_end coinciding with the end-of-emit clear re-arms the flag.
    assign end_pend_d = seq_end | (end_pend_q & ~clear_c);

    assign sig_index = idx_q;
    assign sig_value = min_q[idx_q];
    assign busy      = (state_q != IDLE) | end_pend_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            kmer_q     <= '0;
            end_pend_q <= 1'b0;
            for (int i = 0; i < int'(NUM_HASHES); i++) begin
                min_q[i] <= 32'hFFFF_FFFF;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            kmer_q     <= kmer_d;
            end_pend_q <= end_pend_d;
            for (int i = 0; i < int'(NUM_HASHES); i++) begin
                min_q[i] <= min_d[i];
            end
        end
    end

`ifdef KMER_MINHASH_COUNT_EN
    logic [15:0] count_q, count_d;

    // Saturating count of k-mers consumed in the current sequence.
    always_comb begin
        count_d = count_q;
        if (clear_c) begin
            count_d = '0;
        end else if (kmer_read && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign kmer_count = count_q;
`endif

endmodule

// File: tb/tb_kmer_minhash.sv
// Scoreboard bench for kmer_minhash (NUM_HASHES=2, default hash constants).
module tb_kmer_minhash;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] kmer_data;
    logic        kmer_full;
    logic        kmer_read;
    logic        seq_end;
    logic        sig_valid;
    logic        sig_ready;
    logic [0:0]  sig_index;
    logic [31:0] sig_value;
    logic        busy;
`ifdef KMER_MINHASH_COUNT_EN
    logic [15:0] kmer_count;
`endif

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [0:0]  idx;
        logic [31:0] val;
    } sig_t;

    sig_t exp_q[$];

    kmer_minhash #(.NUM_HASHES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .kmer_data (kmer_data),
        .kmer_full (kmer_full),
        .kmer_read (kmer_read),
        .seq_end   (seq_end),
        .sig_valid (sig_valid),
        .sig_ready (sig_ready),
        .sig_index (sig_index),
        .sig_value (sig_value),
        .busy      (busy)
`ifdef KMER_MINHASH_COUNT_EN
        ,
        .kmer_count(kmer_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every accepted signature word against the scoreboard.
    always @(negedge clk) begin
        if (!rst && kmer_read) begin
            checks++;
            if (!kmer_full) begin
                failures++;
                $display("FAIL kmer_read_without_full: got read=1 full=0 expected full=1");
            end
        end
        if (!rst && sig_valid && sig_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_word: got idx=%0d val=%h expected no word", sig_index, sig_value);
            end else begin
                sig_t e;
                e = exp_q.pop_front();
                if (sig_index !== e.idx || sig_value !== e.val) begin
                    failures++;
                    $display("FAIL sig_word: got idx=%0d val=%h expected idx=%0d val=%h",
                             sig_index, sig_value, e.idx, e.val);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [0:0] i, input logic [31:0] v);
        sig_t s;
        s.idx = i;
        s.val = v;
        exp_q.push_back(s);
    endtask

    task automatic send_kmer(input logic [31:0] v);
        int n;
        kmer_full = 1'b1;
        kmer_data = v;
        n = 0;
        while (!kmer_read && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) begin
            checks++;
            failures++;
            $display("FAIL kmer_read_timeout: got no read expected read within 50 cycles");
        end
        tick();
        kmer_full = 1'b0;
    endtask

    task automatic pulse_end();
        seq_end = 1'b1;
        tick();
        seq_end = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got busy=1 expected idle within 100 cycles", name);
        end
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!sig_valid && n < 100) begin
            tick();
            n++;
        end
        if (n == 100) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got sig_valid=0 expected 1 within 100 cycles", name);
        end
    endtask

    initial begin
        rst       = 1'b1;
        kmer_data = '0;
        kmer_full = 1'b0;
        seq_end   = 1'b0;
        sig_ready = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) tick();

        chk("reset_kmer_read", 32'(kmer_read), 32'd0);
        chk("reset_sig_valid", 32'(sig_valid), 32'd0);
        chk("reset_busy",      32'(busy),      32'd0);
        chk("reset_sig_value", sig_value,      32'hFFFF_FFFF);
        chk("reset_sig_index", 32'(sig_index), 32'd0);

        // x=1 then x=0: x=0 results (0, 1) win.
        push(1'b0, 32'h0000_0000);
        push(1'b1, 32'h0000_0001);
        send_kmer(32'h1);
        send_kmer(32'h0);
        sig_ready = 1'b1;
        pulse_end();
        wait_idle("basic");
`ifdef KMER_MINHASH_COUNT_EN
        chk("count_after_basic", 32'(kmer_count), 32'd0);
`endif

        // Empty sequence: all-ones words, 1-cycle seq_end latency, back to IDLE after 2 accepts.
        push(1'b0, 32'hFFFF_FFFF);
        push(1'b1, 32'hFFFF_FFFF);
        seq_end = 1'b1;
        tick();
        seq_end = 1'b0;
        chk("empty_latency_valid0", 32'(sig_valid), 32'd0);
        chk("empty_latency_busy",   32'(busy),      32'd1);
        tick();
        chk("empty_first_valid",    32'(sig_valid), 32'd1);
        tick();
        chk("empty_second_busy",    32'(busy),      32'd1);
        chk("empty_second_index",   32'(sig_index), 32'd1);
        tick();
        chk("empty_back_idle",      32'(busy),      32'd0);
        chk("empty_valid_low",      32'(sig_valid), 32'd0);

        // Back-pressure: k-mer 2 gives 3C6EF362 / 3C6EF367.
        sig_ready = 1'b0;
        push(1'b0, 32'h3C6E_F362);
        push(1'b1, 32'h3C6E_F367);
        send_kmer(32'h2);
        pulse_end();
        wait_valid("hold");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_valid", 32'(sig_valid), 32'd1);
            chk("hold_index", 32'(sig_index), 32'd0);
            chk("hold_value", sig_value,      32'h3C6E_F362);
        end
        sig_ready = 1'b1;
        wait_idle("hold");

        // seq_end during HASH while a second k-mer waits: k-mers 3 then 5.
        push(1'b0, 32'h1715_6075);
        push(1'b1, 32'h1715_6080);
        sig_ready = 1'b0;
        send_kmer(32'h3);
        kmer_full = 1'b1;
        kmer_data = 32'h5;
        pulse_end();
        send_kmer(32'h5);
        wait_valid("pend");
`ifdef KMER_MINHASH_COUNT_EN
        chk("count_in_emit", 32'(kmer_count), 32'd2);
`endif
        chk("pend_first_index", 32'(sig_index), 32'd0);
        sig_ready = 1'b1;
        wait_idle("pend");
`ifdef KMER_MINHASH_COUNT_EN
        chk("count_after_emit", 32'(kmer_count), 32'd0);
`endif

        // Reset after idx0 accepted: remainder of the signature is dropped.
        push(1'b0, 32'h9E37_79B1);
        sig_ready = 1'b0;
        send_kmer(32'h1);
        pulse_end();
        wait_valid("rst_emit");
        sig_ready = 1'b1;
        tick();
        sig_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_sig_valid", 32'(sig_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_sig_value", sig_value,      32'hFFFF_FFFF);
        chk("rst_sig_index", 32'(sig_index), 32'd0);
`ifdef KMER_MINHASH_COUNT_EN
        chk("rst_count",     32'(kmer_count), 32'd0);
`endif
        sig_ready = 1'b1;
        repeat (10) tick();
        chk("no_words_after_rst", 32'(sig_valid), 32'd0);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
